// File: rtl/ws2812b_pkg.sv
// Shared WS2812B bit timing constants, FSM state encodings and the ns-to-cycle helper.
package ws2812b_pkg;

    localparam int T0H_NS = 400;
    localparam int T0L_NS = 850;
    localparam int T1H_NS = 800;
    localparam int T1L_NS = 450;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_LOAD,
        ST_HIGH,
        ST_LOW
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } phase_t;

    function automatic int ns_to_cycles(input int ns, input int clk_period_ns);
        return ns / clk_period_ns;
    endfunction

endpackage

// File: rtl/ws2812b_bar_driver_bit_encoder.sv
// Single-bit WS2812B waveform generator. Handshake: valid_i is sampled when the encoder is idle
// or on its bit_done_o cycle; a new bit then starts on the next edge with no dead cycle.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic bit_i,
    input  logic valid_i,
    output logic dout_o,
    output logic high_last_o,
    output logic bit_done_o
);

    localparam int T0H_C = ns_to_cycles(T0H_NS, CLK_PERIOD_NS);
    localparam int T0L_C = ns_to_cycles(T0L_NS, CLK_PERIOD_NS);
    localparam int T1H_C = ns_to_cycles(T1H_NS, CLK_PERIOD_NS);
    localparam int T1L_C = ns_to_cycles(T1L_NS, CLK_PERIOD_NS);
    // T0L is the longest of the four phases at any clock period
    localparam int CW = $clog2(T0L_C + 1);
    localparam logic [CW-1:0] T0H_M1 = CW'(T0H_C - 1);
    localparam logic [CW-1:0] T0L_M1 = CW'(T0L_C - 1);
    localparam logic [CW-1:0] T1H_M1 = CW'(T1H_C - 1);
    localparam logic [CW-1:0] T1L_M1 = CW'(T1L_C - 1);

    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic          bit_q;
    logic          dout_q;

    assign dout_o      = dout_q;
    assign high_last_o = (phase_q == PH_HIGH) && (cnt_q == '0);
    assign bit_done_o  = (phase_q == PH_LOW) && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (valid_i) begin
                        phase_q <= PH_HIGH;
                        bit_q   <= bit_i;
                        cnt_q   <= bit_i ? T1H_M1 : T0H_M1;
                        dout_q  <= 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (cnt_q == '0) begin
                        phase_q <= PH_LOW;
                        cnt_q   <= bit_q ? T1L_M1 : T0L_M1;
                        dout_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                PH_LOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (valid_i) begin
                        phase_q <= PH_HIGH;
                        bit_q   <= bit_i;
                        cnt_q   <= bit_i ? T1H_M1 : T0H_M1;
                        dout_q  <= 1'b1;
                    end else begin
                        phase_q <= PH_IDLE;
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ws2812b_bar_driver.sv
// WS2812B bar-graph frame driver: snapshots the meter inputs each frame, selects a zone colour per
// LED and streams GRB bits. Optional peak marker enabled by defining WS2812B_PEAK_HOLD_EN.
module ws2812b_bar_driver
    import ws2812b_pkg::*;
#(
    parameter int CLK_PERIOD_NS    = 10,
    parameter int ZONE_N           = 4,
    parameter int CNT_W            = 16,
    parameter int RESET_NS         = 80000,
    parameter int PEAK_HOLD_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [24*ZONE_N-1:0]    colors,
    input  logic [CNT_W*ZONE_N-1:0] thresholds,
    input  logic [CNT_W-1:0]        on_count,
    input  logic [CNT_W-1:0]        max_count,
    input  logic [23:0]             peak_color,
    output logic                    dout,
    output logic                    busy,
    output logic                    frame_done,
    output state_t                  dbg_state
);

    localparam int GAP_CYC = ns_to_cycles(RESET_NS, CLK_PERIOD_NS);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t                  state_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic [CNT_W-1:0]        led_idx_q;
    logic [4:0]              bit_cnt_q;
    logic [23:0]             sr_q;
    logic [24*ZONE_N-1:0]    colors_q;
    logic [CNT_W*ZONE_N-1:0] thr_q;
    logic [CNT_W-1:0]        on_q;
    logic [CNT_W-1:0]        max_q;
    logic                    busy_q;
    logic                    fd_q;

`ifdef WS2812B_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(PEAK_HOLD_FRAMES);
    logic [CNT_W-1:0]  peak_q;
    logic [HOLD_W-1:0] hold_q;
    logic [23:0]       peakc_q;
`else
    logic unused_peak;
    assign unused_peak = ^peak_color;
`endif

    // Lowest-numbered zone whose threshold exceeds idx wins; unlit LEDs are black.
    function automatic logic [23:0] color_of(input logic [CNT_W-1:0] idx);
        logic [23:0] c;
        c = '0;
        if ((idx < on_q) && (idx < max_q)) begin
            for (int k = ZONE_N - 1; k >= 0; k--) begin
                if (idx < thr_q[CNT_W*k +: CNT_W]) c = colors_q[24*k +: 24];
            end
        end
`ifdef WS2812B_PEAK_HOLD_EN
        if ((peak_q != '0) && (idx == peak_q - CNT_W'(1))) c = peakc_q;
`endif
        return c;
    endfunction

    logic [CNT_W-1:0] led_next;
    logic [23:0]      cur_color;
    logic [23:0]      nxt_color;
    logic             last_bit;
    logic             last_led;
    logic             enc_valid;
    logic             enc_bit;
    logic             enc_high_last;
    logic             enc_bit_done;

    always_comb begin
        led_next  = led_idx_q + CNT_W'(1);
        cur_color = color_of(led_idx_q);
        nxt_color = color_of(led_next);
        last_bit  = (bit_cnt_q == 5'd0);
        last_led  = (led_next == max_q);
        enc_valid = 1'b0;
        enc_bit   = 1'b0;
        if (state_q == ST_LOAD) begin
            enc_valid = 1'b1;
            enc_bit   = cur_color[23];
        end else if ((state_q == ST_LOW) && enc_bit_done && !(last_bit && last_led)) begin
            enc_valid = 1'b1;
            enc_bit   = last_bit ? nxt_color[23] : sr_q[bit_cnt_q - 5'd1];
        end
    end

    ws2812b_bit_encoder #(
        .CLK_PERIOD_NS(CLK_PERIOD_NS)
    ) u_enc (
        .clk_i      (clk),
        .reset_i    (reset),
        .bit_i      (enc_bit),
        .valid_i    (enc_valid),
        .dout_o     (dout),
        .high_last_o(enc_high_last),
        .bit_done_o (enc_bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            led_idx_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            colors_q  <= '0;
            thr_q     <= '0;
            on_q      <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
`ifdef WS2812B_PEAK_HOLD_EN
            peak_q    <= '0;
            hold_q    <= '0;
            peakc_q   <= '0;
`endif
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != GAP_LAST) begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end else begin
                        gap_cnt_q <= '0;
                        if (!enable) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            colors_q  <= colors;
                            thr_q     <= thresholds;
                            on_q      <= on_count;
                            max_q     <= max_count;
                            led_idx_q <= '0;
`ifdef WS2812B_PEAK_HOLD_EN
                            peakc_q <= peak_color;
                            if (on_count > peak_q) begin
                                peak_q <= on_count;
                                hold_q <= '0;
                            end else if (hold_q >= HOLD_MAX) begin
                                if (peak_q != '0) peak_q <= peak_q - CNT_W'(1);
                            end else begin
                                hold_q <= hold_q + HOLD_W'(1);
                            end
`endif
                            // An empty strip completes its frame at once and waits out another gap
                            if (max_count == '0) fd_q <= 1'b1;
                            else state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    sr_q      <= cur_color;
                    bit_cnt_q <= 5'd23;
                    state_q   <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (enc_high_last) state_q <= ST_LOW;
                end
                ST_LOW: begin
                    if (enc_bit_done) begin
                        if (!last_bit) begin
                            bit_cnt_q <= bit_cnt_q - 5'd1;
                            state_q   <= ST_HIGH;
                        end else if (!last_led) begin
                            led_idx_q <= led_next;
                            sr_q      <= nxt_color;
                            bit_cnt_q <= 5'd23;
                            state_q   <= ST_HIGH;
                        end else begin
                            fd_q    <= 1'b1;
                            state_q <= ST_GAP;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ws2812b_bar_driver.sv
// Bench for ws2812b_bar_driver: decodes the serial waveform back into LED colours and checks them
// against a spec-level model. Honours WS2812B_PEAK_HOLD_EN when the build defines it.
module tb_ws2812b_bar_driver;
    import ws2812b_pkg::*;

    localparam int CLK_NS = 100;
    localparam int ZN     = 3;
    localparam int CW     = 16;
    localparam int RST_NS = 50000;
    localparam int HOLD   = 2;
    localparam int TH0    = 400 / CLK_NS;
    localparam int TL0    = 850 / CLK_NS;
    localparam int TH1    = 800 / CLK_NS;
    localparam int TL1    = 450 / CLK_NS;
    localparam int GAP    = RST_NS / CLK_NS;
    localparam int FRAME_BUDGET = GAP + 8 * 24 * 12 + 1000;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [24*ZN-1:0]     colors;
    logic [CW*ZN-1:0]     thresholds;
    logic [CW-1:0]        on_count;
    logic [CW-1:0]        max_count;
    logic [23:0]          peak_color;
    logic                 dout;
    logic                 busy;
    logic                 frame_done;
    state_t               dbg_state;

    int errors = 0;
    int checks = 0;
    logic [23:0]   exp_q[$];
    logic [CW-1:0] exp_len_q[$];
`ifdef WS2812B_PEAK_HOLD_EN
    int m_peak = 0;
    int m_hold = 0;
`endif

    ws2812b_bar_driver #(
        .CLK_PERIOD_NS   (CLK_NS),
        .ZONE_N          (ZN),
        .CNT_W           (CW),
        .RESET_NS        (RST_NS),
        .PEAK_HOLD_FRAMES(HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .colors     (colors),
        .thresholds (thresholds),
        .on_count   (on_count),
        .max_count  (max_count),
        .peak_color (peak_color),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: colour of LED i from the current inputs
    function automatic logic [23:0] model_led(input int i);
        int          on_eff;
        logic [23:0] c;
        on_eff = (on_count > max_count) ? int'(max_count) : int'(on_count);
        c = 24'h0;
        if (i < on_eff) begin
            for (int k = 0; k < ZN; k++) begin
                if (i < int'(thresholds[CW*k +: CW])) begin
                    c = colors[24*k +: 24];
                    break;
                end
            end
        end
`ifdef WS2812B_PEAK_HOLD_EN
        if (m_peak > 0 && i == m_peak - 1) c = peak_color;
`endif
        return c;
    endfunction

    task automatic push_frame();
`ifdef WS2812B_PEAK_HOLD_EN
        if (int'(on_count) > m_peak) begin
            m_peak = int'(on_count);
            m_hold = 0;
        end else if (m_hold >= HOLD) begin
            if (m_peak > 0) m_peak--;
        end else begin
            m_hold++;
        end
`endif
        for (int i = 0; i < int'(max_count); i++) exp_q.push_back(model_led(i));
        exp_len_q.push_back(max_count);
    endtask

    // driver tasks
    task automatic set_bar(input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                           input int t0, input int t1, input int t2, input int on, input int mx);
        colors     = {c2, c1, c0};
        thresholds = {CW'(t2), CW'(t1), CW'(t0)};
        on_count   = CW'(on);
        max_count  = CW'(mx);
        peak_color = 24'($urandom);
    endtask

    task automatic set_random(input int mx_lo);
        for (int k = 0; k < ZN; k++) begin
            colors[24*k +: 24]     = 24'($urandom);
            thresholds[CW*k +: CW] = CW'($urandom_range(0, 9));
        end
        on_count   = CW'($urandom_range(0, 10));
        max_count  = CW'($urandom_range(mx_lo, 8));
        peak_color = 24'($urandom);
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_done: none within %0d cycles", budget);
        end
    endtask

    task automatic wait_dout_high(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dout && n < budget);
        if (!dout) begin
            checks++;
            errors++;
            $display("FAIL wait_dout: no high within %0d cycles", budget);
        end
    endtask

    task automatic gap_wait();
        wait_fd(FRAME_BUDGET);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic scramble(input logic full);
        if (max_count != '0) begin
            wait_dout_high(GAP + 100);
            repeat (100) @(posedge clk);
            #1;
            if (full) set_random(0);
            else on_count = CW'(7);
        end
    endtask

    // monitor: rebuild bits from pulse widths, assemble LEDs, compare with expected queue
    int          hi_len, lo_len, nbits, leds;
    logic        prev_dout, prev_fd, first_of_frame, last_bit, bitv;
    logic [23:0] acc;

    always @(negedge clk) begin
        if (reset) begin
            hi_len = 0; lo_len = 0; nbits = 0; leds = 0; acc = '0;
            prev_dout = 1'b0; prev_fd = 1'b0; first_of_frame = 1'b1; last_bit = 1'b0;
        end else begin
            if (dout) begin
                if (!prev_dout) begin
                    checks++;
                    if (first_of_frame) begin
                        if (lo_len < GAP) begin
                            errors++;
                            $display("FAIL gap_len: got %0d expected >= %0d", lo_len, GAP);
                        end
                        first_of_frame = 1'b0;
                    end else if (lo_len != (last_bit ? TL1 : TL0)) begin
                        errors++;
                        $display("FAIL low_time: got %0d expected %0d", lo_len, last_bit ? TL1 : TL0);
                    end
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev_dout) begin
                    checks++;
                    bitv = (hi_len == TH1);
                    if (hi_len != TH1 && hi_len != TH0) begin
                        errors++;
                        $display("FAIL high_time: got %0d expected %0d or %0d", hi_len, TH0, TH1);
                    end
                    acc = {acc[22:0], bitv};
                    last_bit = bitv;
                    nbits++;
                    if (nbits == 24) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL led_color: got %06h with nothing expected", acc);
                        end else begin
                            check("led_color", 32'(acc), 32'(exp_q.pop_front()));
                        end
                        nbits = 0;
                        leds++;
                    end
                    lo_len = 0;
                end
                lo_len++;
            end
            if (frame_done) begin
                check("fd_single_pulse", 32'(prev_fd), 32'd0);
                check("fd_bit_align", 32'(nbits), 32'd0);
                if (exp_len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_len: got %0d LEDs with no frame expected", leds);
                end else begin
                    check("frame_len", 32'(leds), 32'(exp_len_q.pop_front()));
                end
                leds = 0;
                nbits = 0;
                first_of_frame = 1'b1;
            end
            prev_dout = dout;
            prev_fd   = frame_done;
        end
    end

    // stimulus
    initial begin
        int n;
        reset  = 1'b1;
        enable = 1'b0;
        set_bar(24'h0, 24'h0, 24'h0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fd", 32'(frame_done), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1 reset = 1'b0;

        // single LED, first bit 1 then 23 zeros
        set_bar(24'h800000, 24'h00ff00, 24'h0000ff, 1, 0, 0, 1, 1);
        push_frame();
        enable = 1'b1;

        // peak sequence 6, 2, 2, 2
        gap_wait(); set_bar(24'h112233, 24'h445566, 24'h778899, 2, 4, 6, 6, 8); push_frame(); scramble(1'b1);
        for (int f = 0; f < 3; f++) begin
            gap_wait(); set_bar(24'h112233, 24'h445566, 24'h778899, 2, 4, 6, 2, 8); push_frame(); scramble(1'b1);
        end

        // three zones, partial fill
        gap_wait(); set_bar(24'hff0000, 24'h00ff00, 24'h0000ff, 2, 4, 6, 5, 8); push_frame(); scramble(1'b1);
        // on_count changed mid-frame must not leak into the running frame
        gap_wait(); set_bar(24'hff0000, 24'h00ff00, 24'h0000ff, 2, 4, 6, 3, 8); push_frame(); scramble(1'b0);
        gap_wait(); set_bar(24'hff0000, 24'h00ff00, 24'h0000ff, 2, 4, 6, 7, 8); push_frame(); scramble(1'b1);
        // unordered thresholds, clamp, empty strip
        gap_wait(); set_bar(24'habcdef, 24'h123456, 24'h0f0f0f, 5, 2, 9, 12, 6); push_frame(); scramble(1'b1);
        gap_wait(); set_bar(24'hffffff, 24'hffffff, 24'hffffff, 3, 3, 3, 3, 0); push_frame();

        for (int f = 0; f < 5; f++) begin
            gap_wait(); set_random(0); push_frame(); scramble(1'b1);
        end

        // drop enable while LED 2 of 8 is on the wire
        gap_wait(); set_random(8); push_frame();
        wait_dout_high(GAP + 100);
        repeat (2 * 24 * 12 + 30) @(posedge clk);
        #1 enable = 1'b0;
        wait_fd(FRAME_BUDGET);
        n = 0;
        while (busy && n < GAP + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < GAP - 1 || n > GAP + 1) begin
            errors++;
            $display("FAIL idle_after_gap: busy low after %0d cycles expected %0d", n, GAP);
        end
        check("drop_pending_leds", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // reset while a HIGH phase is on the wire
        set_random(4); push_frame();
        enable = 1'b1;
        wait_dout_high(GAP + 100);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_dout", 32'(dout), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_fd", 32'(frame_done), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        exp_len_q.delete();
`ifdef WS2812B_PEAK_HOLD_EN
        m_peak = 0;
        m_hold = 0;
`endif
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // recovery frame from a clean state
        @(posedge clk);
        #1 set_random(1); push_frame();
        enable = 1'b1;
        wait_fd(FRAME_BUDGET);
        #1 enable = 1'b0;
        n = 0;
        while (busy && n < GAP + 50) begin
            @(negedge clk);
            n++;
        end
        check("final_busy", 32'(busy), 32'd0);
        check("final_leds_left", 32'(exp_q.size()), 32'd0);
        check("final_frames_left", 32'(exp_len_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
